// File: rtl/pg_carry_resolver.sv
// Two-stage carry resolver: S1 registers p/g plus 4-bit group P/G, S2 resolves carries.
// Optional feature macro: PG_RESOLVER_OVF_EN (registers signed overflow; otherwise ovf = 0).
module pg_carry_resolver #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p_in,
    input  logic [WIDTH-1:0] g_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = int'(WIDTH / 4);

    logic             in_fire;
    logic             s2_load;

    logic             s1_valid_d, s1_valid_q;
    logic [WIDTH-1:0] s1_p_d, s1_p_q;
    logic [WIDTH-1:0] s1_g_d, s1_g_q;
    logic             s1_cin_d, s1_cin_q;
    logic [NG-1:0]    s1_gp_d, s1_gp_q;
    logic [NG-1:0]    s1_gg_d, s1_gg_q;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;

    logic [NG:0]      gc;
    logic [WIDTH:0]   c;

    // Ready never looks at in_valid, so upstream may gate valid on ready safely.
    assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);

    always_comb begin
        s1_gp_d = s1_gp_q;
        s1_gg_d = s1_gg_q;
        s1_p_d   = s1_p_q;
        s1_g_d   = s1_g_q;
        s1_cin_d = s1_cin_q;
        if (in_fire) begin
            s1_p_d   = p_in;
            s1_g_d   = g_in;
            s1_cin_d = cin;
            for (int k = 0; k < NG; k++) begin
                s1_gp_d[k] = &p_in[4*k +: 4];
                s1_gg_d[k] = g_in[4*k+3]
                           | (p_in[4*k+3] & g_in[4*k+2])
                           | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
                           | (p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & g_in[4*k]);
            end
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Group carries as flat sum-of-products over GG/GP, so no carry crosses groups serially.
    always_comb begin
        logic prod;
        gc    = '0;
        prod  = 1'b1;
        gc[0] = s1_cin_q;
        for (int k = 0; k < NG; k++) begin
            prod = 1'b1;
            for (int j = k; j >= 0; j--) begin
                gc[k+1] = gc[k+1] | (s1_gg_q[j] & prod);
                prod    = prod & s1_gp_q[j];
            end
            gc[k+1] = gc[k+1] | (prod & s1_cin_q);
        end
    end

    always_comb begin
        logic prod;
        c    = '0;
        prod = 1'b1;
        for (int k = 0; k < NG; k++) begin
            c[4*k] = gc[k];
            for (int i = 0; i < 4; i++) begin
                prod = 1'b1;
                for (int j = i; j >= 0; j--) begin
                    c[4*k+i+1] = c[4*k+i+1] | (s1_g_q[4*k+j] & prod);
                    prod       = prod & s1_p_q[4*k+j];
                end
                c[4*k+i+1] = c[4*k+i+1] | (prod & gc[k]);
            end
        end
    end

    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        if (s2_load) begin
            sum_d  = s1_p_q ^ c[WIDTH-1:0];
            cout_d = c[WIDTH];
        end
        if (s2_load) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_p_q      <= '0;
            s1_g_q      <= '0;
            s1_cin_q    <= 1'b0;
            s1_gp_q     <= '0;
            s1_gg_q     <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_p_q      <= s1_p_d;
            s1_g_q      <= s1_g_d;
            s1_cin_q    <= s1_cin_d;
            s1_gp_q     <= s1_gp_d;
            s1_gg_q     <= s1_gg_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
        end
    end

`ifdef PG_RESOLVER_OVF_EN
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = ovf_q;
        if (s2_load) begin
            ovf_d = c[WIDTH] ^ c[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_pg_carry_resolver.sv
// Scoreboard bench for pg_carry_resolver: driver pushes expected results, a monitor pops on output.
module tb_pg_carry_resolver;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] p_in = '0;
    logic [W-1:0] g_in = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t         sb[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    int           stalls = 0;
    bit           held_v = 1'b0;
    logic [W+1:0] held;

    pg_carry_resolver #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p_in      (p_in),
        .g_in      (g_in),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic exp_ovf(logic v);
`ifdef PG_RESOLVER_OVF_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic c);
        logic [W:0] full;
        res_t       r;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = exp_ovf((a[W-1] == b[W-1]) && (full[W-1] != a[W-1]));
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one transaction; push its expected result at the negedge before the accepting edge.
    task automatic send(logic [W-1:0] p, logic [W-1:0] g, logic c,
                        logic [W-1:0] es, logic ec, logic eo);
        int   waited;
        res_t r;
        waited   = 0;
        in_valid = 1'b1;
        p_in     = p;
        g_in     = g;
        cin      = c;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            stalls++;
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready 0, expected 1 within 50 cycles");
        end else begin
            r.sum  = es;
            r.cout = ec;
            r.ovf  = eo;
            sb.push_back(r);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                if (held_v) check("hold_stable", 32'({sum, cout, ovf}), 32'(held));
                held_v = 1'b1;
                held   = {sum, cout, ovf};
            end else begin
                held_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got sum 0x%0h, expected no result", sum);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    check("result", 32'({sum, cout, ovf}), 32'({e.sum, e.cout, e.ovf}));
                end
            end
        end
    end

    task automatic drain(string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        res_t         r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Basic add with latency check: accepted at edge N, visible after edge N+1.
        send(16'h00FE, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        check("lat_edge_n", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_edge_n1", 32'(out_valid), 32'd1);
        drain("basic_drain");

        @(posedge clk);
        #1;
        send(16'hFFFE, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        send(16'h7FFE, 16'h0001, 1'b0, 16'h8000, 1'b0, exp_ovf(1'b1));
        drain("directed_drain");

        // Backpressure: two accepted, third refused until out_ready rises.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(16'h0F0F, 16'h0000, 1'b1, 16'h0F10, 1'b0, 1'b0);
        send(16'h0000, 16'h8000, 1'b0, 16'h0000, 1'b1, exp_ovf(1'b1));
        in_valid = 1'b1;
        p_in     = 16'h5115;
        g_in     = 16'h0220;
        cin      = 1'b0;
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_first_sum", 32'(sum), 32'h0F10);
        repeat (3) @(posedge clk);
        #1;
        check("full_still_blocked", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        send(16'h5115, 16'h0220, 1'b0, 16'h5555, 1'b0, 1'b0);
        drain("bp_drain");

        // Streaming at full rate.
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            c = 1'($urandom);
            r = model(a, b, c);
            send(a ^ b, a & b, c, r.sum, r.cout, r.ovf);
        end
        check("stream_stalls", 32'(stalls), 32'd0);
        drain("stream_drain");

        // Reset with both stages full.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(16'h7FFF, 16'h8000, 1'b0, 16'h7FFF, 1'b1, exp_ovf(1'b1));
        send(16'h5115, 16'h0220, 1'b0, 16'h5555, 1'b0, 1'b0);
        check("pre_reset_sum", 32'({sum, cout}), 32'({16'h7FFF, 1'b1}));
        check("pre_reset_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_cout_ovf", 32'({cout, ovf}), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("no_stale_result", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pg_carry_resolver.md
# pg_carry_resolver

Pipelined carry-resolution stage that sits downstream of a row of half adders. It consumes the per-bit propagate (p = a ^ b) and generate (g = a & b) vectors plus a carry-in. It resolves all carries with two-level lookahead over 4-bit groups and returns the registered sum, carry-out and signed overflow. A valid/ready handshake on both sides lets it drop into streaming datapaths with backpressure.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  p_in/g_in/cin hold a valid transaction.
- in_ready  output  1  block accepts a transaction this cycle.
- p_in  input  WIDTH  per-bit propagate, a ^ b.
- g_in  input  WIDTH  per-bit generate, a & b.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum/cout/ovf hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- sum  output  WIDTH  p ^ carries.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow, c[WIDTH] ^ c[WIDTH-1].

## Operation
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage 1 (S1) captures the following on input transfer:
  - p, g and cin.
  - Per-group GP[k] = &p[4k+3:4k].
  - Per-group GG[k] = g3 | p3g2 | p3p2g1 | p3p2p1g0 for group k.
- Stage 2 (S2) loads from S1 when S1 is valid and S2 is empty or being drained:
  - Group carries: C[0] = cin; C[k+1] = GG[k] | GP[k]&C[k], fully expanded, not rippled.
  - Bit carries within each group come from 4-bit lookahead seeded by C[k].
  - Registers sum = p ^ c[WIDTH-1:0], cout = c[WIDTH] and ovf.
- Occupancy: each stage holds one valid bit and one transaction. No skid buffer.
- in_ready = !s1_valid || (!s2_valid || out_ready). It is combinational from out_ready and state only, never from in_valid.
- S2 output registers hold their value while out_valid && !out_ready.
- Simultaneous events:
  - S2 drain and S1→S2 move happen in the same cycle.
  - New input enters S1 in that same cycle, giving full throughput of one result per cycle.
- Illegal input (p&g ≠ 0) is not checked. Arithmetic uses the given vectors as-is.
- Reset values, asynchronous on rst_n low:
  - s1_valid = 0, out_valid = 0.
  - sum = 0, cout = 0, ovf = 0.
  - in_ready = 1 after reset.
  - All in-flight transactions are discarded.

## Timing
- Latency is 2 cycles. A transaction accepted at edge N has out_valid high after edge N+1.
- Throughput is 1 per cycle while out_ready = 1.
- Full condition: with out_ready held 0, at most 2 transactions are accepted. in_ready falls once S1 and S2 are both valid.
- Empty condition: out_valid = 0 and sum/cout/ovf keep their last value, except after reset, when they are 0.
- Critical path is S2 group lookahead plus in-group lookahead plus XOR, with no WIDTH-long ripple.
- rst_n deassertion is synchronous to clk from the system reset bridge. The first transfer is possible on the first edge after release.

## Configuration
- PG_RESOLVER_OVF_EN defined:
  - c[WIDTH-1] is carried into S2.
  - ovf is registered with the result.
- PG_RESOLVER_OVF_EN undefined:
  - ovf is tied to 0.
  - No extra S2 storage is built.
  - All other behaviour is identical.

## Test plan
- Basic add: a=0x00FF, b=0x0001 → p=0x00FE, g=0x0001, cin=0. Expect sum=0x0100, cout=0, ovf=0 exactly 2 cycles after acceptance.
- Full-width carry chain: p=0xFFFE, g=0x0001, cin=0. Expect sum=0x0000, cout=1, ovf=0. Then p=0xFFFF, g=0, cin=1. Expect sum=0x0000, cout=1.
- Signed overflow: p=0x7FFE, g=0x0001, cin=0. Expect sum=0x8000, cout=0. Expect ovf=1 with PG_RESOLVER_OVF_EN, 0 without.
- Backpressure: hold out_ready=0 and offer 3 back-to-back transactions.
  - Expect exactly 2 accepted and in_ready=0 on the third.
  - Expect out_valid=1 with the first sum stable.
  - Raise out_ready: expect results in order, 1 per cycle, with no loss or duplication.
- Streaming: 100 random (a,b,cin) with out_ready=1. Expect one result per cycle, each matching a+b+cin after 2 cycles.
- Reset mid-operation: pull rst_n low with S1 and S2 full.
  - Expect out_valid=0, sum=0, cout=0, ovf=0 immediately, with no clock needed.
  - Expect in_ready=1 after release and no stale result to emerge.
